rkv_fgen: RTL

Multi-channel pattern generator with a non-invasive override path, replacing testbench `force` on design outputs. Each channel runs a free-running generator (increment or walking-one). A valid/ready override port temporarily substitutes a supplied value on one channel's output for a programmed number of cycles. The generator keeps running underneath the override, and the output returns to the live generator value on release. The block sits between stimulus/debug logic and the DUT ports it drives.

---
 rtl/rkv_fgen_pkg.sv | 24 ++
 rtl/rkv_fgen_chan.sv | 98 +++++++++
 rtl/rkv_fgen.sv | 58 +++++
 3 files changed

// File: rtl/rkv_fgen_pkg.sv
// Shared types and constants for the multi-channel pattern generator.
package rkv_fgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVR  = 2'd2,
        DONE = 2'd3
    } fgen_state_e;

    typedef enum logic {
        INC   = 1'b0,
        SHIFT = 1'b1
    } fgen_mode_e;

    localparam int SEED_INC   = 0;
    localparam int SEED_SHIFT = 1;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rkv_fgen_chan.sv
// One generator channel: free-running INC/SHIFT pattern with a timed override.
// Outputs are state registers plus a mux (zero latency); busy blocks new overrides.
module rkv_fgen_chan
    import rkv_fgen_pkg::*;
#(
    parameter int DW     = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              acc,
    input  logic [DW-1:0]     ovr_data,
    input  logic [HOLD_W-1:0] ovr_len,
    output logic [DW-1:0]     out_p,
    output logic              out_ovr,
    output logic              done,
    output logic              busy
);

    fgen_state_e       state_q, state_d, plain_d, ret_q;
    logic [DW-1:0]     gen_q, gen_d, ovr_q, seed, gen_step;
    logic [HOLD_W-1:0] hold_q;
    logic              term_q, term_d, adv, hit;

    // Generator datapath; under an override it only advances if it was running.
    always_comb begin
        seed     = (mode == SHIFT) ? DW'(SEED_SHIFT) : DW'(SEED_INC);
        gen_step = (mode == SHIFT) ? {gen_q[DW-2:0], 1'b0} : gen_q + 1'b1;
        adv      = en && ((state_q == RUN) ||
                          ((state_q == OVR) && (ret_q == RUN) && !term_q));
        hit      = adv && ((mode == SHIFT) ? (gen_step == '0) : (gen_step == '1));
        gen_d    = gen_q;
        if (state_q == IDLE)
            gen_d = seed;
        else if (adv)
            gen_d = gen_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // plain_d is where the channel would go without an override; it becomes
    // the return state when an override is accepted.
    always_comb begin
        plain_d = state_q;
        term_d  = 1'b0;
        case (state_q)
            IDLE:    if (en)   plain_d = RUN;
            RUN:     if (hit)  plain_d = DONE;
            DONE:    if (!en)  plain_d = IDLE;
            OVR:     plain_d = state_q;
            default: plain_d = IDLE;
        endcase
        state_d = plain_d;
        if (state_q == OVR) begin
            term_d = term_q || hit;
            if (hold_q == '0)
                state_d = term_d ? DONE : ret_q;
        end else if (acc) begin
            state_d = OVR;
            term_d  = hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_q  <= '0;
            ovr_q  <= '0;
            hold_q <= '0;
            ret_q  <= IDLE;
            term_q <= 1'b0;
        end else begin
            gen_q  <= gen_d;
            term_q <= term_d;
            if (acc && (state_q != OVR)) begin
                ovr_q  <= ovr_data;
                hold_q <= ovr_len;
                ret_q  <= plain_d;
            end else if ((state_q == OVR) && (hold_q != '0)) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    always_comb begin
        busy    = (state_q == OVR);
        out_ovr = busy;
        done    = (state_q == DONE);
        out_p   = busy ? ovr_q : gen_q;
    end

endmodule

// File: rtl/rkv_fgen.sv
// Multi-channel pattern generator with a valid/ready override port.
// Zero-cycle outputs; ovr_ready is combinational and low while the target channel is overridden.
module rkv_fgen
    import rkv_fgen_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DW     = 4,
    parameter int HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCH-1:0]         mode,
    input  logic                   ovr_valid,
    output logic                   ovr_ready,
    input  logic [ch_w(NCH)-1:0]   ovr_ch,
    input  logic [DW-1:0]          ovr_data,
    input  logic [HOLD_W-1:0]      ovr_len,
    output logic [NCH*DW-1:0]      out_p,
    output logic [NCH-1:0]         out_ovr,
    output logic [NCH-1:0]         done
);

    localparam int CHW = ch_w(NCH);

    logic [NCH-1:0] busy, acc;

    // An out-of-range select matches no channel and so is never ready.
    always_comb begin
        ovr_ready = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (ovr_ch == CHW'(c))
                ovr_ready = !busy[c];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign acc[c] = ovr_valid && ovr_ready && (ovr_ch == CHW'(c));

        rkv_fgen_chan #(
            .DW     (DW),
            .HOLD_W (HOLD_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (mode[c]),
            .acc      (acc[c]),
            .ovr_data (ovr_data),
            .ovr_len  (ovr_len),
            .out_p    (out_p[c*DW +: DW]),
            .out_ovr  (out_ovr[c]),
            .done     (done[c]),
            .busy     (busy[c])
        );
    end

endmodule
